// File: rtl/int_pkg.sv
// Shared types for the interrupt scheduler: FSM state encoding and the
// EPC/level stack entry.
package int_pkg;

    localparam int unsigned NSrc = 3;
    localparam int unsigned PcW  = 32;
    localparam int unsigned LvlW = $clog2(NSrc + 1);

    typedef enum logic [1:0] {
        StIdle,
        StTake,
        StGuard
    } state_e;

    // Entry widths follow the package constants; the scheduler's default parameters match them.
    typedef struct packed {
        logic [PcW-1:0]  epc;
        logic [LvlW-1:0] level;
    } stk_entry_t;

endpackage

// File: rtl/int_prio_enc.sv
// Masked priority encoder: highest pending source whose level (k+1) exceeds the
// current service level.
module int_prio_enc import int_pkg::*; #(
    parameter int unsigned N_SRC = NSrc,
    localparam int unsigned LVL_W = $clog2(N_SRC + 1),
    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] pend_i,
    input  logic [LVL_W-1:0] level_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Ascending scan so the highest qualifying index is the one left standing.
        for (int k = 0; k < int'(N_SRC); k++) begin
            if (pend_i[k] && ((k + 1) > int'(level_i))) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/int_sched.sv
// Nested priority interrupt scheduler: edge capture, entry/return flush pulses,
// and an EPC/level stack for redirect and return.
module int_sched import int_pkg::*; #(
    parameter int unsigned      N_SRC      = NSrc,
    parameter int unsigned      PC_W       = PcW,
    parameter logic [PC_W-1:0]  VEC_BASE   = 32'h0000_0100,
    parameter logic [PC_W-1:0]  VEC_STRIDE = 32'h0000_0040,
    parameter int unsigned      GUARD_CYC  = 4,
    localparam int unsigned     LVL_W      = $clog2(N_SRC + 1),
    localparam int unsigned     IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int unsigned     CNT_W      = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_i,
    input  logic             ie_i,
    input  logic [PC_W-1:0]  epc_i,
    input  logic             eret_req_i,
    output logic             interrupt_o,
    output logic             eret_o,
    output logic [PC_W-1:0]  vector_o,
    output logic [PC_W-1:0]  epc_o,
    output logic [LVL_W-1:0] level_o,
    output logic [N_SRC-1:0] pending_o,
    output logic             stk_err_o
);

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   irq_q, irq_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   take_idx_q, take_idx_d;
    logic               eret_hold_q, eret_hold_d;
    logic               err_q, err_d;
    logic               intr_q, intr_d;
    logic               eret_q, eret_d;
    logic [PC_W-1:0]    vector_q, vector_d;
    logic [PC_W-1:0]    epc_q, epc_d;
    stk_entry_t         stk_q [N_SRC];
    stk_entry_t         stk_d [N_SRC];

    logic               cand_valid;
    logic [IDX_W-1:0]   cand_idx;
    logic [N_SRC-1:0]   pend_clr;
    logic [LVL_W-1:0]   top_idx;

    int_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .pend_i  (pend_q),
        .level_i (level_q),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    assign top_idx = sp_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        irq_d       = irq_i;
        level_d     = level_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        take_idx_d  = take_idx_q;
        eret_hold_d = eret_hold_q;
        err_d       = err_q;
        intr_d      = 1'b0;
        eret_d      = 1'b0;
        vector_d    = vector_q;
        epc_d       = epc_q;
        stk_d       = stk_q;
        pend_clr    = '0;

        case (state_q)
            StIdle: begin
                // Return takes priority over a new entry in the same cycle.
                if (eret_req_i || eret_hold_q) begin
                    eret_hold_d = 1'b0;
                    if (sp_q != '0) begin
                        eret_d  = 1'b1;
                        epc_d   = stk_q[top_idx].epc;
                        level_d = stk_q[top_idx].level;
                        sp_d    = top_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (cand_valid && ie_i) begin
                    state_d    = StTake;
                    take_idx_d = cand_idx;
                    intr_d     = 1'b1;
                    vector_d   = VEC_BASE + (PC_W'(cand_idx) * VEC_STRIDE);
                end
            end
            StTake: begin
                stk_d[sp_q].epc   = epc_i;
                stk_d[sp_q].level = level_q;
                sp_d              = sp_q + 1'b1;
                level_d           = LVL_W'(take_idx_q) + 1'b1;
                pend_clr[take_idx_q] = 1'b1;
                cnt_d             = CNT_W'(GUARD_CYC - 1);
                state_d           = StGuard;
                if (eret_req_i) eret_hold_d = 1'b1;
            end
            StGuard: begin
                if (eret_req_i) eret_hold_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh edge wins over the clear of a source being taken this cycle.
        pend_d = (pend_q & ~pend_clr) | (irq_i & ~irq_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            irq_q       <= '0;
            pend_q      <= '0;
            level_q     <= '0;
            sp_q        <= '0;
            cnt_q       <= '0;
            take_idx_q  <= '0;
            eret_hold_q <= 1'b0;
            err_q       <= 1'b0;
            intr_q      <= 1'b0;
            eret_q      <= 1'b0;
            vector_q    <= '0;
            epc_q       <= '0;
            for (int i = 0; i < int'(N_SRC); i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            pend_q      <= pend_d;
            level_q     <= level_d;
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            take_idx_q  <= take_idx_d;
            eret_hold_q <= eret_hold_d;
            err_q       <= err_d;
            intr_q      <= intr_d;
            eret_q      <= eret_d;
            vector_q    <= vector_d;
            epc_q       <= epc_d;
            stk_q       <= stk_d;
        end
    end

    assign interrupt_o = intr_q;
    assign eret_o      = eret_q;
    assign vector_o    = vector_q;
    assign epc_o       = epc_q;
    assign level_o     = level_q;
    assign pending_o   = pend_q;
    assign stk_err_o   = err_q;

endmodule
